// File: rtl/pipe_stage_reg.sv
//-----------------------------------------------------------------------------
// pipe_stage_reg
//
// Flushable inter-stage pipeline register with a valid/ready handshake.
// It carries a DATA_W payload and a CTRL_W control vector. The control
// vector is forced to zero whenever the stage holds no valid entry, so a
// bubble can never carry live control bits (RegWrite, MemWrite, ...)
// downstream.
//
// SKID=1 : two-entry skid buffer. oReady comes straight from a register and
//          has no combinational path from iReady. Stalls therefore do not
//          create long ready chains across stages.
// SKID=0 : single entry. oReady = ~oValid | iReady (combinational).
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset (highest priority)
//   flush   in   synchronous squash of every held entry (branch/jump kill)
//   iValid  in   upstream presents an entry
//   oReady  out  stage accepts an entry this cycle
//   iData   in   upstream payload  [DATA_W]
//   iCtrl   in   upstream control  [CTRL_W]
//   oValid  out  stage presents an entry downstream
//   iReady  in   downstream accepts this cycle
//   oData   out  head payload      [DATA_W]
//   oCtrl   out  head control      [CTRL_W], zero while oValid=0
//   oCount  out  entries held (0..2, at most 1 when SKID=0)
//-----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic [CTRL_W-1:0] iCtrl,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [CTRL_W-1:0] oCtrl,
  output logic [1:0]        oCount
);

  // The state encoding equals the number of held entries, so oCount is
  // simply the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam bit useSkid = (SKID != 0);

  state_t              state_r;
  state_t              stateNext_s;
  logic [DATA_W-1:0]   headData_r;
  logic [DATA_W-1:0]   headDataNext_s;
  logic [CTRL_W-1:0]   headCtrl_r;
  logic [CTRL_W-1:0]   headCtrlNext_s;
  logic [DATA_W-1:0]   skidData_r;
  logic [DATA_W-1:0]   skidDataNext_s;
  logic [CTRL_W-1:0]   skidCtrl_r;
  logic [CTRL_W-1:0]   skidCtrlNext_s;
  logic                validReg_r;
  logic                readyReg_r;
  logic                inFire_s;
  logic                outFire_s;

  // With the skid buffer the ready is a pure register; without it the
  // stage can accept whenever it is empty or the head leaves this cycle.
  assign oReady    = useSkid ? readyReg_r : (~validReg_r | iReady);
  assign inFire_s  = iValid & oReady;
  assign outFire_s = validReg_r & iReady;

  assign oValid = validReg_r;
  assign oData  = headData_r;
  assign oCtrl  = headCtrl_r;
  assign oCount = state_r;

  // Next-state and next-entry computation: flush first, then the handshake FSM.
  always_comb begin
    stateNext_s    = state_r;
    headDataNext_s = headData_r;
    headCtrlNext_s = headCtrl_r;
    skidDataNext_s = skidData_r;
    skidCtrlNext_s = skidCtrl_r;

    if (flush) begin
      // Any in_fire in this cycle is deliberately dropped together with
      // the held entries.
      stateNext_s    = EMPTY;
      headDataNext_s = {DATA_W{1'b0}};
      headCtrlNext_s = {CTRL_W{1'b0}};
      skidDataNext_s = {DATA_W{1'b0}};
      skidCtrlNext_s = {CTRL_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (inFire_s) begin
            stateNext_s    = ONE;
            headDataNext_s = iData;
            headCtrlNext_s = iCtrl;
          end else begin
            stateNext_s = EMPTY;
          end
        end
        ONE: begin
          // Without a skid slot an accepted entry always replaces the
          // head; oReady guarantees the head leaves in the same cycle.
          if (inFire_s && (outFire_s || !useSkid)) begin
            stateNext_s    = ONE;
            headDataNext_s = iData;
            headCtrlNext_s = iCtrl;
          end else if (inFire_s) begin
            stateNext_s    = TWO;
            skidDataNext_s = iData;
            skidCtrlNext_s = iCtrl;
          end else if (outFire_s) begin
            // Bubble: control is killed, payload is left as-is.
            stateNext_s    = EMPTY;
            headCtrlNext_s = {CTRL_W{1'b0}};
          end else begin
            stateNext_s = ONE;
          end
        end
        TWO: begin
          // oReady is low here, so only the drain side can move.
          if (outFire_s) begin
            stateNext_s    = ONE;
            headDataNext_s = skidData_r;
            headCtrlNext_s = skidCtrl_r;
            skidDataNext_s = {DATA_W{1'b0}};
            skidCtrlNext_s = {CTRL_W{1'b0}};
          end else begin
            stateNext_s = TWO;
          end
        end
        default: begin
          stateNext_s    = EMPTY;
          headDataNext_s = {DATA_W{1'b0}};
          headCtrlNext_s = {CTRL_W{1'b0}};
          skidDataNext_s = {DATA_W{1'b0}};
          skidCtrlNext_s = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State, entry storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= EMPTY;
      headData_r <= {DATA_W{1'b0}};
      headCtrl_r <= {CTRL_W{1'b0}};
      skidData_r <= {DATA_W{1'b0}};
      skidCtrl_r <= {CTRL_W{1'b0}};
      validReg_r <= 1'b0;
      readyReg_r <= 1'b1;
    end else begin
      state_r    <= stateNext_s;
      headData_r <= headDataNext_s;
      headCtrl_r <= headCtrlNext_s;
      skidData_r <= skidDataNext_s;
      skidCtrl_r <= skidCtrlNext_s;
      validReg_r <= (stateNext_s != EMPTY);
      readyReg_r <= (stateNext_s != TWO);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, flushable inter-stage pipeline register with valid/ready handshake. It is the successor to the fixed ID/EX-style field-by-field registers.
- Carries a DATA_W payload plus a CTRL_W control vector. Control bits are forced to zero whenever the stage holds a bubble.
- Optional 2-entry skid buffer (SKID=1) registers the upstream ready. This breaks the combinational ready path when stalls are introduced between IF/ID/EX/MEM/WB.

Parameters:
- DATA_W, 32, payload width (PC+4, operands, immediates, register indices).
- CTRL_W, 16, control width (RegWrite, MemRead, MemWrite, etc.). Cleared on bubble, flush and reset.
- SKID, 1, 1 = two-entry skid buffer with registered oReady; 0 = single entry with combinational oReady.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch/jump squash).
- iValid  in  1  upstream has an entry.
- oReady  out  1  stage can accept an entry this cycle.
- iData  in  DATA_W  upstream payload.
- iCtrl  in  CTRL_W  upstream control vector.
- oValid  out  1  stage presents an entry downstream.
- iReady  in  1  downstream accepts this cycle.
- oData  out  DATA_W  head payload.
- oCtrl  out  CTRL_W  head control; zero whenever oValid=0.
- oCount  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Transfer definitions:
  - in_fire = iValid & oReady.
  - out_fire = oValid & iReady.
- Reset (reset=1 at clk edge):
  - oValid=0, oData=0, oCtrl=0, oCount=0.
  - Skid entry is cleared.
  - oReady=1 on the cycle after reset.
- Priority order: reset > flush > normal operation.
- Flush:
  - Same result as reset: all entries dropped; oData, oCtrl and oCount become 0.
  - An in_fire in the same cycle is discarded.
  - oReady stays as computed (1 after a flush with SKID=1).
- State machine for SKID=1 (state = oCount):
  - EMPTY: in_fire -> ONE; head <= input.
  - ONE, in_fire & out_fire: stay ONE; head <= input.
  - ONE, in_fire & ~out_fire: -> TWO; skid <= input; head held.
  - ONE, ~in_fire & out_fire: -> EMPTY; oCtrl <= 0, oData holds.
  - ONE, no fire: hold.
  - TWO, out_fire: -> ONE; head <= skid, skid cleared.
  - TWO, no out_fire: hold.
  - oReady = (state != TWO), driven from a register with no combinational path from iReady.
  - Because oReady=0 in TWO, in_fire cannot occur there.
- SKID=0:
  - Single entry; oReady = ~oValid | iReady (combinational).
  - in_fire loads head.
  - out_fire without in_fire -> EMPTY; oCtrl <= 0.
  - oCount is 0 or 1 only.
- Latency and throughput:
  - One cycle from in_fire to oValid.
  - Full throughput (one entry per cycle) in both modes when iReady is held at 1.
- Stability: while oValid=1 and iReady=0, oData and oCtrl hold constant.
- Ordering: strict FIFO; no entry duplicated or lost except by flush or reset.
- Inputs are ignored when iValid=0: no state change from iData/iCtrl.
- Width rules:
  - oCount is exactly 2 bits.
  - DATA_W >= 1 and CTRL_W >= 1; no arithmetic on the payload.
- Reset asserted mid-stall (state TWO) empties both entries in one cycle.

Test Plan:
- Stream, SKID=1: iReady=1, iValid=1, iData=1,2,3,4 on consecutive cycles -> oData=1,2,3,4 one cycle later, oValid continuous, oCount=1 throughout.
- Back-pressure, SKID=1: load A=0x10, B=0x20 with iReady=0 -> oCount=2, oReady=0, oData=0x10 held; raise iReady -> 0x10 then 0x20 delivered in order, oReady back to 1 one cycle after first out_fire.
- Flush, SKID=1: with oCount=2 (ctrl 0x00FF, 0x0F0F) and iValid=1 iCtrl=0xAAAA, assert flush for one cycle -> next cycle oValid=0, oCtrl=0, oData=0, oCount=0; 0xAAAA never appears.
- Bubble clear: single entry ctrl=0x8001 consumed with iValid=0 -> next cycle oValid=0, oCtrl=0x0000, oData retains payload.
- Reset mid-operation: oCount=2, assert reset while flush=0 and iValid=1 -> next cycle all outputs 0, oReady=1; deassert and send 0x55 -> oData=0x55 after one cycle.
- SKID=0: iReady=0 with entry held -> oReady=0; same cycle iReady=1, iValid=1, iData=0x7 -> oReady=1 combinationally, next cycle oData=0x7, oCount=1.
